// File: rtl/mips_pkg.sv
// Shared MIPS definitions: multiply/divide op codes, sequencer state encoding
// and op-class helpers.
package mips_pkg;

  localparam int unsigned MD_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_RUN  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } md_state_e;

  function automatic logic op_is_div(input md_op_e o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input md_op_e o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration on the 2*WIDTH working register: right shift-add for multiply,
// left shift with restoring compare-subtract for divide.
module muldiv_step
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic               is_div_i,
  input  logic [2*WIDTH-1:0] work_i,
  input  logic [WIDTH-1:0]   opnd_i,
  output logic [2*WIDTH-1:0] work_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  // sum keeps the multiply carry; diff[WIDTH] set means the trial subtract borrowed
  always_comb begin
    sum  = {1'b0, work_i[2*WIDTH-1:WIDTH]} + {1'b0, opnd_i};
    diff = work_i[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_i};
    if (is_div_i) begin
      if (!diff[WIDTH]) begin
        work_o = {diff[WIDTH-1:0], work_i[WIDTH-2:0], 1'b1};
      end else begin
        work_o = {work_i[2*WIDTH-2:0], 1'b0};
      end
    end else if (work_i[0]) begin
      work_o = {sum, work_i[WIDTH-1:1]};
    end else begin
      work_o = {1'b0, work_i[2*WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MIPS MULT/MULTU/DIV/DIVU unit: sign fix-up around an unsigned
// 32-step iterative core, fixed 34-cycle latency, results in HI/LO.
module muldiv_sequencer
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             busy,
  output logic             done,
  output logic             divByZero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned WW    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH);

  md_state_e        state_q, state_d;
  md_op_e           op_q, op_d;
  logic [WW-1:0]    work_q, work_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dbz_q, dbz_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_out_q, dbz_out_d;

  logic [WW-1:0]    step_work;
  logic [WW-1:0]    prod;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic             a_neg;
  logic             b_neg;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i (op_is_div(op_q)),
    .work_i   (work_q),
    .opnd_i   (opnd_q),
    .work_o   (step_work)
  );

  // Next-state and datapath control
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    work_d    = work_q;
    opnd_d    = opnd_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dbz_d     = dbz_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    a_neg = op_is_signed(op_q) & work_q[WIDTH-1];
    b_neg = op_is_signed(op_q) & opnd_q[WIDTH-1];
    prod  = neg_res_q ? WW'(0) - work_q : work_q;
    quot  = neg_res_q ? WIDTH'(0) - work_q[WIDTH-1:0] : work_q[WIDTH-1:0];
    rem   = neg_rem_q ? WIDTH'(0) - work_q[WW-1:WIDTH] : work_q[WW-1:WIDTH];

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = md_op_e'(op);
          work_d  = {WIDTH'(0), opA};
          opnd_d  = opB;
          state_d = ST_PREP;
        end
      end
      ST_PREP: begin
        work_d    = {WIDTH'(0), a_neg ? WIDTH'(0) - work_q[WIDTH-1:0] : work_q[WIDTH-1:0]};
        opnd_d    = b_neg ? WIDTH'(0) - opnd_q : opnd_q;
        neg_res_d = a_neg ^ b_neg;
        neg_rem_d = a_neg;
        dbz_d     = op_is_div(op_q) && (opnd_q == '0);
        cnt_d     = '0;
        state_d   = ST_RUN;
      end
      ST_RUN: begin
        work_d = step_work;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        // Divide by zero leaves the dividend in the remainder half already
        if (op_is_div(op_q)) begin
          hi_d = rem;
          lo_d = dbz_q ? '1 : quot;
        end else begin
          hi_d = prod[WW-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
    dbz_out_d = done_d & dbz_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_MULT;
      work_q    <= '0;
      opnd_q    <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      work_q    <= work_d;
      opnd_q    <= opnd_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dbz_q     <= dbz_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dbz_out_q <= dbz_out_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign divByZero = dbz_out_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule
